spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- 16-bit SPI master: the initiating end of the link whose responder is the existing SPI slave (ports rstb/ten/tdata/sck/mosi/miso/done/rdata).
- Generates ss, sck and mosi from the system clock and captures miso.
- Uses SPI mode 3 (CPOL=1, CPHA=1): sck idles high, data is launched on the falling sck edge and sampled on the rising edge.
- Bit order is selectable per transfer; this matches the slave's mlb convention.

Parameters:
- DATA_W, 16: transfer length in bits; must equal the slave's word width.
- CLK_DIV, 4: sck half-period in clk cycles (H); legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rstb  input  1  asynchronous, active-low reset.
- start  input  1  request a transfer; sampled only in IDLE.
- mlb  input  1  bit order, captured with start: 1 = MSB first, 0 = LSB first.
- tdata  input  DATA_W  word to transmit, captured with start.
- miso  input  1  serial data from the slave.
- ss  output  1  active-low slave select.
- sck  output  1  serial clock; idles high.
- mosi  output  1  serial data to the slave.
- busy  output  1  high from start acceptance until the block is back in IDLE.
- done  output  1  one-clk pulse; rdata is valid in the same cycle.
- rdata  output  DATA_W  last received word; held between transfers.

Behaviour:
- Reset (asynchronous, any state): ss=1, sck=1, mosi=0, busy=0, done=0, rdata=0, FSM=IDLE, counters=0.
- Reset mid-transfer: aborts immediately, no done pulse, rdata keeps 0.
- States: IDLE -> LEAD -> SHIFT -> LAG -> GAP -> IDLE.
- IDLE:
  - start=1 at clk edge T0: latch tdata into tx shift register and mlb into the order flag.
  - At T0: ss<=0, busy<=1, go to LEAD.
  - start=0: stay in IDLE.
- LEAD: H cycles with ss low and sck high.
- SHIFT: bit k (k = 0..DATA_W-1):
  - At T0+(2k+1)H: sck<=0 and mosi<=bit k.
  - At T0+(2k+2)H: sck<=1 and miso is sampled into the rx shift register.
- Bit order:
  - mlb=1: bit k = tdata[DATA_W-1-k]; rx shifts left and the first received bit ends in rdata[DATA_W-1].
  - mlb=0: bit k = tdata[k]; rx shifts right and the first received bit ends in rdata[0].
- LAG: after the last rising edge at T0+2*DATA_W*H, hold ss low and sck high for H cycles.
- End of LAG, at T0+(2*DATA_W+1)H:
  - ss<=1, mosi<=0.
  - rdata<=rx register, done=1 for exactly one cycle.
  - Go to GAP.
- GAP: ss high for H cycles (minimum deselect time). busy<=0 at T0+(2*DATA_W+2)H, then IDLE.
- Default timing (DATA_W=16, H=4): done at T0+132, busy falls at T0+136.
- start handling:
  - start while busy=1 is ignored; no queueing.
  - start held high continuously is accepted on the first cycle back in IDLE, giving back-to-back transfers with ss high for ≥H+1 cycles.
- tdata/mlb changes after T0 have no effect on the current transfer.
- sck high and low phases are each exactly H clk cycles; no glitches; sck=1 whenever ss=1.
- Half-period counter: ceil(log2(CLK_DIV+1)) bits, reloads at each phase boundary. Bit counter: ceil(log2(DATA_W+1)) bits, counts down.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset values: assert rstb=0 with start toggling -> ss=1, sck=1, mosi=0, busy=0, done=0, rdata=0; release rstb and idle 50 cycles -> outputs unchanged.
- MSB-first loopback (miso tied to mosi), H=4:
  - Stimulus: start pulse, mlb=1, tdata=16'hAAAA.
  - Response: mosi sequence 1,0,1,0... on falling edges; 16 sck falling edges; done pulse at T0+132; rdata=16'hAAAA; busy low at T0+136.
- LSB-first against the SPI slave model:
  - Stimulus: slave tdata=16'h1234; master mlb=0, tdata=16'hAFAF.
  - Response: slave rdata=16'hAFAF, master rdata=16'h1234, single done pulse.
- Back-to-back: start held high with tdata=16'h00FF then 16'hFF00 (loopback) -> two done pulses 137 cycles apart; ss high for ≥5 cycles between transfers; rdata updates 16'h00FF then 16'hFF00.
- Ignore while busy / latch: second start pulse and tdata change to 16'h5555 at T0+40 -> no effect; rdata=original word; exactly one done.
- Abort: rstb=0 at T0+60 -> ss=1 and sck=1 immediately (asynchronous); no done pulse; rdata=0. CLK_DIV=1 run -> sck period 2 clk cycles, done at T0+33.

Source files
------------

// File: rtl/spi_master.sv
// spi_master: mode-3 SPI master with per-transfer bit order and programmable sck half-period
module spi_master #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic              mlb,
  input  logic [DATA_W-1:0] tdata,
  input  logic              miso,
  output logic              ss,
  output logic              sck,
  output logic              mosi,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] H_M1 = CW'(CLK_DIV - 1);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEAD  = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] LAG   = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bits_q, bits_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
  logic              msb_q, msb_d, ss_q, ss_d, sck_q, sck_d, mosi_q, mosi_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              tick, launch, sample;
  assign tick   = cnt_q == '0;
  // falling sck edges launch the next bit, rising edges sample miso
  assign launch = tick && (state_q == LEAD || (state_q == SHIFT && sck_q));
  assign sample = tick && state_q == SHIFT && !sck_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || tick) ? H_M1 : cnt_q - 1'b1;
    bits_d  = bits_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    msb_d   = msb_q;
    ss_d    = ss_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    if (launch) begin
      sck_d  = 1'b0;
      mosi_d = msb_q ? tx_q[DATA_W-1] : tx_q[0];
      tx_d   = msb_q ? tx_q << 1 : tx_q >> 1;
    end
    if (sample) begin
      sck_d  = 1'b1;
      rx_d   = msb_q ? {rx_q[DATA_W-2:0], miso} : {miso, rx_q[DATA_W-1:1]};
      bits_d = bits_q - 1'b1;
    end
    case (state_q)
      IDLE: if (start) begin
        state_d = LEAD;
        tx_d    = tdata;
        msb_d   = mlb;
        ss_d    = 1'b0;
        busy_d  = 1'b1;
      end
      LEAD: if (tick) begin
        state_d = SHIFT;
        bits_d  = BW'(DATA_W);
      end
      SHIFT: if (sample && bits_q == BW'(1)) state_d = LAG;
      LAG: if (tick) begin
        state_d = GAP;
        ss_d    = 1'b1;
        mosi_d  = 1'b0;
        rdata_d = rx_q;
        done_d  = 1'b1;
      end
      GAP: if (tick) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      msb_q   <= 1'b0;
      ss_q    <= 1'b1;
      sck_q   <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      msb_q   <= msb_d;
      ss_q    <= ss_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end
  assign ss    = ss_q;
  assign sck   = sck_q;
  assign mosi  = mosi_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master with loopback and a behavioural SPI slave
module tb_spi_master;
  localparam int W = 16;
  localparam int H = 4;
  typedef struct {logic [W-1:0] d; int t0;} exp_t;
  logic clk = 1'b0, rstb = 1'b1, start = 1'b0, mlb = 1'b0;
  logic miso, ss, sck, mosi, busy, done;
  logic [W-1:0] tdata = '0, rdata;
  logic start1 = 1'b0, ss1, sck1, mosi1, busy1, done1;
  logic [W-1:0] tdata1 = '0, rdata1;
  logic loop = 1'b1, s_miso = 1'b0, s_mlb = 1'b0;
  logic [W-1:0] s_tx = '0, s_rx = '0;
  int s_k = 0;
  int cyc = 0, n_chk = 0, n_fail = 0, last_t0 = 0, last_done = -1000;
  int run = 0, falls = 0;
  logic prev_ss = 1'b1, prev_sck = 1'b1, chk_en = 1'b0;
  exp_t q[$], q1[$];
  spi_master #(.DATA_W(W), .CLK_DIV(H)) dut (
    .clk(clk), .rstb(rstb), .start(start), .mlb(mlb), .tdata(tdata), .miso(miso),
    .ss(ss), .sck(sck), .mosi(mosi), .busy(busy), .done(done), .rdata(rdata));
  spi_master #(.DATA_W(W), .CLK_DIV(1)) dut1 (
    .clk(clk), .rstb(rstb), .start(start1), .mlb(1'b1), .tdata(tdata1), .miso(mosi1),
    .ss(ss1), .sck(sck1), .mosi(mosi1), .busy(busy1), .done(done1), .rdata(rdata1));
  assign miso = loop ? mosi : s_miso;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // slave: launches on falling sck, samples on rising sck, bit order from s_mlb
  always @(negedge sck or negedge ss)
    if (!ss) begin
      if (sck) s_k = 0;
      else begin
        s_miso = s_tx[s_mlb ? W - 1 - s_k : s_k];
        s_k++;
      end
    end
  always @(posedge sck)
    if (!ss) s_rx = s_mlb ? {s_rx[W-2:0], mosi} : {mosi, s_rx[W-1:1]};
  always @(negedge clk) begin
    exp_t e;
    if (prev_sck && !sck) falls++;
    if (prev_ss && !ss) begin
      falls = 0;
      chk(run >= H + 1, "ss_gap", run, H + 1);
    end
    if (sck !== prev_sck || ss !== prev_ss) begin
      if (!prev_ss && chk_en) chk(run == H, "sck_phase", run, H);
      run = 1;
    end else run++;
    if (ss) chk(sck == 1'b1, "sck_idle", sck, 1);
    if (done) begin
      chk(q.size() != 0, "unexpected_done", rdata, 0);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk(rdata == e.d, "rdata", rdata, e.d);
        chk(cyc == e.t0 + (2 * W + 1) * H, "done_time", cyc, e.t0 + (2 * W + 1) * H);
        chk(falls == W, "sck_falls", falls, W);
        last_done = cyc;
      end
    end
    if (cyc == last_done + H - 1) chk(busy == 1'b1, "busy_hold", busy, 1);
    if (cyc == last_done + H) chk(busy == 1'b0, "busy_fall", busy, 0);
    prev_ss = ss;
    prev_sck = sck;
  end
  always @(negedge clk)
    if (done1) begin
      exp_t e;
      chk(q1.size() != 0, "unexpected_done1", rdata1, 0);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk(rdata1 == e.d, "rdata_div1", rdata1, e.d);
        chk(cyc == e.t0 + 2 * W + 1, "done_time_div1", cyc, e.t0 + 2 * W + 1);
      end
    end
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(!busy, "idle_timeout", busy, 0);
  endtask
  task automatic xfer(input logic [W-1:0] d, input logic m, input logic [W-1:0] exp);
    wait_idle();
    start = 1'b1;
    tdata = d;
    mlb = m;
    last_t0 = cyc + 1;
    q.push_back('{d: exp, t0: last_t0});
    @(negedge clk);
    start = 1'b0;
    tdata = W'($urandom);
    mlb = 1'($urandom);
  endtask
  task automatic check_reset(input string nm);
    chk(ss == 1'b1, {nm, "_ss"}, ss, 1);
    chk(sck == 1'b1, {nm, "_sck"}, sck, 1);
    chk(mosi == 1'b0, {nm, "_mosi"}, mosi, 0);
    chk(busy == 1'b0, {nm, "_busy"}, busy, 0);
    chk(done == 1'b0, {nm, "_done"}, done, 0);
    chk(rdata == '0, {nm, "_rdata"}, rdata, 0);
  endtask
  initial begin
    logic [W-1:0] d;
    logic m;
    int n;
    #1 rstb = 1'b0;
    repeat (4) begin
      @(negedge clk);
      start = ~start;
    end
    check_reset("rst");
    @(negedge clk);
    start = 1'b0;
    rstb = 1'b1;
    repeat (50) @(negedge clk);
    check_reset("idle");
    chk_en = 1'b1;
    xfer(16'hAAAA, 1'b1, 16'hAAAA);
    wait_idle();
    loop = 1'b0;
    s_tx = 16'h1234;
    s_mlb = 1'b0;
    xfer(16'hAFAF, 1'b0, 16'h1234);
    wait_idle();
    chk(s_rx == 16'hAFAF, "slave_rdata", s_rx, 16'hAFAF);
    loop = 1'b1;
    start = 1'b1;
    tdata = 16'h00FF;
    mlb = 1'b1;
    last_t0 = cyc + 1;
    q.push_back('{d: 16'h00FF, t0: last_t0});
    q.push_back('{d: 16'hFF00, t0: last_t0 + (2 * W + 2) * H + 1});
    @(negedge clk);
    tdata = 16'hFF00;
    while (cyc < last_t0 + (2 * W + 2) * H + 1) @(negedge clk);
    start = 1'b0;
    xfer(16'h3C5A, 1'b1, 16'h3C5A);
    while (cyc < last_t0 + 40) @(negedge clk);
    start = 1'b1;
    tdata = 16'h5555;
    mlb = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (8) begin
      wait_idle();
      d = W'($urandom);
      m = 1'($urandom);
      loop = 1'($urandom);
      s_tx = W'($urandom);
      s_mlb = m;
      xfer(d, m, loop ? d : s_tx);
      wait_idle();
      if (!loop) chk(s_rx == d, "slave_rdata_rand", s_rx, d);
    end
    loop = 1'b1;
    start = 1'b1;
    tdata = 16'hBEEF;
    mlb = 1'b1;
    last_t0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < last_t0 + 60) @(negedge clk);
    chk_en = 1'b0;
    #2 rstb = 1'b0;
    #1 check_reset("abort");
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (150) @(negedge clk);
    chk(rdata == '0, "abort_rdata_kept", rdata, 0);
    chk_en = 1'b1;
    start1 = 1'b1;
    tdata1 = 16'h6D2B;
    q1.push_back('{d: 16'h6D2B, t0: cyc + 1});
    @(negedge clk);
    start1 = 1'b0;
    tdata1 = '0;
    n = 0;
    while ((q.size() != 0 || q1.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(q.size() == 0, "pending_main", q.size(), 0);
    chk(q1.size() == 0, "pending_div1", q1.size(), 0);
    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
